// File: rtl/ram_wr_pkg.sv
// Shared types and pattern function for the RAM write/readback self-test.
package ram_wr_pkg;

    localparam int PAT_W = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_DRAIN,
        S_DONE
    } ram_wr_state_t;

    // Caller truncates to DATA_W, which yields the modulo-2^DATA_W sum.
    function automatic logic [PAT_W-1:0] ram_wr_pattern(
        input logic [PAT_W-1:0] addr,
        input logic [PAT_W-1:0] base
    );
        return addr + base;
    endfunction

endpackage

// File: rtl/ram_wr_verify_if.sv
// RAM port A bundle between the self-test sequencer and the block RAM.
interface ram_wr_verify_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8
);
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_din;
    logic [DATA_W-1:0] ram_dout;

    modport master (
        output ram_we,
        output ram_addr,
        output ram_din,
        input  ram_dout
    );

    modport slave (
        input  ram_we,
        input  ram_addr,
        input  ram_din,
        output ram_dout
    );
endinterface

// File: rtl/ram_wr_cmp.sv
// Readback comparator: delayed valid/address, error counter, first-error latch.
module ram_wr_cmp
    import ram_wr_pkg::*;
#(
    parameter int                ADDR_W   = 5,
    parameter int                DATA_W   = 8,
    parameter logic [DATA_W-1:0] PAT_BASE = 8'hA5
) (
    input  logic              sys_clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              issue,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] dout,
    output logic              hit,
    output logic [ADDR_W:0]   err_cnt,
    output logic [ADDR_W-1:0] first_err_addr
);

    logic              v_q;
    logic [ADDR_W-1:0] a_q;
    logic [DATA_W-1:0] exp_d;

    assign exp_d = DATA_W'(ram_wr_pattern(PAT_W'(a_q), PAT_W'(PAT_BASE)));
    assign hit   = v_q && (dout != exp_d);

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q            <= 1'b0;
            a_q            <= '0;
            err_cnt        <= '0;
            first_err_addr <= '0;
        end else if (clr) begin
            v_q            <= 1'b0;
            a_q            <= '0;
            err_cnt        <= '0;
            first_err_addr <= '0;
        end else begin
            v_q <= issue;
            a_q <= addr;
            if (hit) begin
                err_cnt <= err_cnt + 1'b1;
                if (err_cnt == '0)
                    first_err_addr <= a_q;
            end
        end
    end

endmodule

// File: rtl/ram_wr_verify.sv
// RAM fill/readback self-test sequencer; RAM_WR_ERR_INJECT_EN flips bit 0
// of the word written at INJ_ADDR.
module ram_wr_verify
    import ram_wr_pkg::*;
#(
    parameter int                ADDR_W   = 5,
    parameter int                DATA_W   = 8,
    parameter logic [DATA_W-1:0] PAT_BASE = 8'hA5,
    parameter int                INJ_ADDR = 3
) (
    input  logic              sys_clk,
    input  logic              rst_n,
    input  logic              start,
    ram_wr_verify_if.master   ram,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ADDR_W:0]   err_cnt,
    output logic [ADDR_W-1:0] first_err_addr
);

`ifdef RAM_WR_ERR_INJECT_EN
    localparam bit INJ_ON = 1'b1;
`else
    localparam bit INJ_ON = 1'b0;
`endif

    localparam logic [ADDR_W-1:0] ADDR_MAX = '1;
    localparam logic [ADDR_W-1:0] INJ_A    = ADDR_W'(INJ_ADDR);

    ram_wr_state_t     state;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] din_q;
    logic              clr;
    logic              issue;
    logic              hit;

    function automatic logic [DATA_W-1:0] wdata(input logic [ADDR_W-1:0] a);
        logic [DATA_W-1:0] d;
        d    = DATA_W'(ram_wr_pattern(PAT_W'(a), PAT_W'(PAT_BASE)));
        d[0] = d[0] ^ (INJ_ON && (a == INJ_A));
        return d;
    endfunction

    assign ram.ram_we   = we_q;
    assign ram.ram_addr = addr_q;
    assign ram.ram_din  = din_q;

    assign clr   = start && (state == S_IDLE || state == S_DONE);
    assign issue = (state == S_READ);

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            we_q   <= 1'b0;
            addr_q <= '0;
            din_q  <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            pass   <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state  <= S_WRITE;
                        we_q   <= 1'b1;
                        addr_q <= '0;
                        din_q  <= wdata('0);
                        busy   <= 1'b1;
                        pass   <= 1'b0;
                    end
                end
                S_WRITE: begin
                    if (addr_q == ADDR_MAX) begin
                        state  <= S_READ;
                        we_q   <= 1'b0;
                        addr_q <= '0;
                    end else begin
                        addr_q <= addr_q + 1'b1;
                        din_q  <= wdata(addr_q + 1'b1);
                    end
                end
                S_READ: begin
                    if (addr_q == ADDR_MAX)
                        state <= S_DRAIN;
                    else
                        addr_q <= addr_q + 1'b1;
                end
                S_DRAIN: begin
                    // Last compare lands on this edge, so fold it into pass.
                    state <= S_DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    pass  <= (err_cnt == '0) && !hit;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    ram_wr_cmp #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .PAT_BASE (PAT_BASE)
    ) u_cmp (
        .sys_clk        (sys_clk),
        .rst_n          (rst_n),
        .clr            (clr),
        .issue          (issue),
        .addr           (addr_q),
        .dout           (ram.ram_dout),
        .hit            (hit),
        .err_cnt        (err_cnt),
        .first_err_addr (first_err_addr)
    );

endmodule

// File: tb/tb_ram_wr_verify.sv
// Directed bench for ram_wr_verify with a 1-cycle RAM model and result scoreboard.
module tb_ram_wr_verify;
    import ram_wr_pkg::*;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 32;

`ifdef RAM_WR_ERR_INJECT_EN
    localparam bit INJ = 1'b1;
`else
    localparam bit INJ = 1'b0;
`endif

    typedef struct {
        int   err;
        int   first;
        logic pass;
    } exp_t;

    logic              sys_clk = 1'b0;
    logic              rst_n   = 1'b0;
    logic              start   = 1'b0;
    logic              busy;
    logic              done;
    logic              pass;
    logic [ADDR_W:0]   err_cnt;
    logic [ADDR_W-1:0] first_err_addr;

    logic [DATA_W-1:0] mem       [DEPTH];
    logic              force_en  [DEPTH];
    logic [DATA_W-1:0] force_val [DEPTH];
    logic [DATA_W-1:0] wr_seen   [DEPTH];

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    ram_wr_verify_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) ram ();

    ram_wr_verify dut (
        .sys_clk        (sys_clk),
        .rst_n          (rst_n),
        .start          (start),
        .ram            (ram),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .err_cnt        (err_cnt),
        .first_err_addr (first_err_addr)
    );

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) begin
        if (ram.ram_we)
            mem[ram.ram_addr] <= ram.ram_din;
        ram.ram_dout <= force_en[ram.ram_addr] ? force_val[ram.ram_addr]
                                               : mem[ram.ram_addr];
    end

    always @(negedge sys_clk) begin
        if (ram.ram_we)
            wr_seen[ram.ram_addr] = ram.ram_din;
    end

    function automatic logic [DATA_W-1:0] pat(input int a);
        return DATA_W'(ram_wr_pattern(PAT_W'(a), PAT_W'(8'hA5)));
    endfunction

    function automatic logic [DATA_W-1:0] wr_model(input int a);
        logic [DATA_W-1:0] d;
        d = pat(a);
        if (INJ && a == 3)
            d[0] = ~d[0];
        return d;
    endfunction

    function automatic exp_t predict();
        exp_t e;
        logic [DATA_W-1:0] rd;
        e.err   = 0;
        e.first = 0;
        for (int a = 0; a < DEPTH; a++) begin
            rd = force_en[a] ? force_val[a] : wr_model(a);
            if (rd != pat(a)) begin
                if (e.err == 0)
                    e.first = a;
                e.err++;
            end
        end
        e.pass = (e.err == 0);
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_we"},    32'(ram.ram_we),   32'd0);
        chk({tag, "_addr"},  32'(ram.ram_addr), 32'd0);
        chk({tag, "_din"},   32'(ram.ram_din),  32'd0);
        chk({tag, "_busy"},  32'(busy),         32'd0);
        chk({tag, "_done"},  32'(done),         32'd0);
        chk({tag, "_pass"},  32'(pass),         32'd0);
        chk({tag, "_err"},   32'(err_cnt),      32'd0);
        chk({tag, "_first"}, 32'(first_err_addr), 32'd0);
    endtask

    task automatic clear_faults();
        for (int a = 0; a < DEPTH; a++) begin
            force_en[a]  = 1'b0;
            force_val[a] = '0;
        end
    endtask

    // g1/g2: cycles after E at which start is pulsed again (0 = none).
    task automatic run(input string tag, input int g1, input int g2);
        exp_t e;
        int   busy_n;
        int   done_n;
        int   done_at;
        int   k;
        for (int a = 0; a < DEPTH; a++)
            wr_seen[a] = 'x;
        sb.push_back(predict());
        busy_n  = 0;
        done_n  = 0;
        done_at = 0;
        @(negedge sys_clk);
        start = 1'b1;
        @(posedge sys_clk);
        k = 0;
        while (k < 200 && (done_at == 0 || k < done_at + 2)) begin
            @(negedge sys_clk);
            k++;
            start = (k == g1 || k == g2);
            if (k == 1) begin
                chk({tag, "_clr_err"},   32'(err_cnt),        32'd0);
                chk({tag, "_clr_first"}, 32'(first_err_addr), 32'd0);
                chk({tag, "_clr_pass"},  32'(pass),           32'd0);
            end
            if (busy)
                busy_n++;
            if (done) begin
                done_n++;
                if (done_at == 0)
                    done_at = k;
            end
        end
        start = 1'b0;
        chk({tag, "_done_cyc"},  32'(done_at), 32'd66);
        chk({tag, "_done_cnt"},  32'(done_n),  32'd1);
        chk({tag, "_busy_len"},  32'(busy_n),  32'd65);
        e = sb.pop_front();
        chk({tag, "_err_cnt"},   32'(err_cnt),        32'(e.err));
        chk({tag, "_first_err"}, 32'(first_err_addr), 32'(e.first));
        chk({tag, "_pass"},      32'(pass),           32'(e.pass));
        for (int a = 0; a < DEPTH; a++)
            chk($sformatf("%s_wr%0d", tag, a), 32'(wr_seen[a]), 32'(wr_model(a)));
    endtask

    initial begin
        clear_faults();
        for (int a = 0; a < DEPTH; a++) begin
            mem[a]     = '0;
            wr_seen[a] = 'x;
        end
        ram.ram_dout = '0;

        repeat (3) @(negedge sys_clk);
        chk_reset("rst");
        rst_n = 1'b1;

        run("clean", 0, 0);
        chk("wr_a0",  32'(wr_seen[0]),  32'h0000_00A5);
        chk("wr_a31", 32'(wr_seen[31]), 32'h0000_00C4);
        if (INJ)
            chk("wr_inj3", 32'(wr_seen[3]), 32'h0000_00A9);
        else
            chk("wr_a3", 32'(wr_seen[3]), 32'h0000_00A8);

        force_en[7]  = 1'b1;
        force_val[7] = 8'h00;
        run("loc7", 0, 0);

        clear_faults();
        force_en[2]   = 1'b1;
        force_val[2]  = pat(2) ^ 8'hFF;
        force_en[9]   = 1'b1;
        force_val[9]  = pat(9) ^ 8'hFF;
        force_en[31]  = 1'b1;
        force_val[31] = pat(31) ^ 8'hFF;
        run("multi", 0, 0);

        run("ignore", 10, 40);

        clear_faults();
        run("rerun", 0, 0);

        @(negedge sys_clk);
        start = 1'b1;
        @(negedge sys_clk);
        start = 1'b0;
        repeat (38) @(negedge sys_clk);
        chk("mid_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        @(negedge sys_clk);
        chk_reset("midrst");
        rst_n = 1'b1;
        @(negedge sys_clk);
        chk_reset("postrst");

        run("fresh", 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
